// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Sole driver of a byte-wide, single-port main memory, shared between the
//   instruction-fetch port and the data (load/store) port. Each accepted
//   request becomes a burst of 1, 2 or 4 little-endian byte accesses. Read
//   bytes are assembled into a zero-extended word.
//
//   Build option: define MEM_ARB_DATA_PRIORITY_EN to make the data port win
//   every contested grant. Left undefined, contested grants alternate
//   round-robin.
//
//   Flow: IDLE -> BUSY (one memory byte per cycle) -> RESP (one-cycle done)
//   -> IDLE.

module mem_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    // instruction fetch port (always a full word)
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_done,
    output logic [LEN-1:0]        inst_data,

    // data load/store port
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [LEN-1:0]        data_wdata,
    output logic                  data_done,
    output logic [LEN-1:0]        data_rdata,

    // memory bus
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal,
    output logic [BYTE_SIZE-1:0]  writen_data,
    input  logic [BYTE_SIZE-1:0]  mem_data
);

    // Memory operation codes.
    localparam logic [1:0] SIG_IDLE      = 2'b00;
    localparam logic [1:0] SIG_READ_INST = 2'b01;
    localparam logic [1:0] SIG_READ_DATA = 2'b10;
    localparam logic [1:0] SIG_WRITE     = 2'b11;

    // A word holds LANES bytes. The byte counter must reach LANES, because a
    // read spends one extra cycle capturing its last byte.
    localparam int LANES  = LEN / BYTE_SIZE;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

    state_t                state_q;
    state_t                state_d;
    port_t                 grant_q;     // port that owns the current burst
    port_t                 grant_sel;   // port that would win in IDLE this cycle
    logic [ADDR_WIDTH-1:0] base_q;      // latched start address
    logic                  we_q;        // latched store flag
    logic [LEN-1:0]        wdata_q;     // latched store data
    logic [CNT_W-1:0]      n_q;         // burst length in bytes
    logic [CNT_W-1:0]      n_sel;       // burst length of the request in IDLE
    logic [CNT_W-1:0]      cnt_q;       // byte index of the current cycle
    logic [CNT_W-1:0]      cnt_prev;    // byte index captured this cycle
    logic [LANE_W-1:0]     wr_lane;
    logic [LANE_W-1:0]     rd_lane;
    logic [LEN-1:0]        rbuf_q;      // partially assembled read word
    logic [LEN-1:0]        rd_word;     // rbuf_q plus the byte captured this cycle
    logic [LEN-1:0]        inst_data_q;
    logic [LEN-1:0]        data_rdata_q;
    logic                  accept;      // grant a request at the coming edge
    logic                  burst_end;   // last cycle of the burst
    logic                  capture;     // mem_data holds a byte to capture
    logic                  bus_active;  // a byte access is issued this cycle

`ifndef MEM_ARB_DATA_PRIORITY_EN
    port_t                 last_grant_q;
`endif

    // Arbitration: pick the winning port from the current requests.
    // NOTE: Every variable written in an always_comb block gets a default on
    // the first line. Any path that leaves a variable unassigned would infer a
    // latch.
    always_comb begin
        grant_sel = PORT_INST;
`ifdef MEM_ARB_DATA_PRIORITY_EN
        if (data_req) begin
            grant_sel = PORT_DATA;
        end
`else
        if (inst_req && data_req) begin
            grant_sel = (last_grant_q == PORT_INST) ? PORT_DATA : PORT_INST;
        end else if (data_req) begin
            grant_sel = PORT_DATA;
        end
`endif
    end

    // Burst length of the winning request. Fetches are always a full word,
    // and size 11 is treated as a word.
    always_comb begin
        n_sel = CNT_W'(LANES);
        if (grant_sel == PORT_DATA) begin
            case (data_size)
                2'b00:   n_sel = CNT_W'(1);
                2'b01:   n_sel = CNT_W'(2);
                default: n_sel = CNT_W'(LANES);
            endcase
        end
    end

    // State register.
    // NOTE: Sequential state is assigned with <= so that every flop samples
    // values from before the edge, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and burst control strobes.
    // A write ends on the edge that commits its last byte. A read needs one
    // more cycle, because the memory returns data a cycle after the address.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        burst_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (we_q) begin
                    burst_end = (cnt_q == n_q - CNT_W'(1));
                end else begin
                    burst_end = (cnt_q == n_q);
                end
                if (burst_end) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // No grant in this cycle. A request still held is seen in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte lanes. The capture lane trails the issue lane by one cycle.
    assign cnt_prev = cnt_q - CNT_W'(1);
    assign wr_lane  = cnt_q[LANE_W-1:0];
    assign rd_lane  = cnt_prev[LANE_W-1:0];
    assign capture  = (state_q == ST_BUSY) && !we_q && (cnt_q != '0);

    // Merge the byte arriving from memory into the partial read word.
    always_comb begin
        rd_word = rbuf_q;
        if (capture) begin
            rd_word[rd_lane*BYTE_SIZE +: BYTE_SIZE] = mem_data;
        end
    end

    // Request latch, byte counter, read assembly and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= PORT_INST;
            base_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            rbuf_q       <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
`ifndef MEM_ARB_DATA_PRIORITY_EN
            last_grant_q <= PORT_INST;
`endif
        end else if (accept) begin
            // Snapshot the request. Later changes on the requester inputs
            // have no effect until this burst completes.
            grant_q <= grant_sel;
            n_q     <= n_sel;
            cnt_q   <= '0;
            rbuf_q  <= '0;
`ifndef MEM_ARB_DATA_PRIORITY_EN
            last_grant_q <= grant_sel;
`endif
            if (grant_sel == PORT_DATA) begin
                base_q  <= data_addr;
                we_q    <= data_we;
                wdata_q <= data_wdata;
            end else begin
                base_q  <= inst_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (capture) begin
                rbuf_q <= rd_word;
            end
            // Publish a completed read to its port. The value holds until
            // that port's next completed read.
            if (burst_end && !we_q) begin
                if (grant_q == PORT_INST) begin
                    inst_data_q <= rd_word;
                end else begin
                    data_rdata_q <= rd_word;
                end
            end
        end
    end

    // The bus is driven only while bytes are still being issued. It is forced
    // idle during reset, so a burst aborted mid-way commits no further bytes.
    assign bus_active = (state_q == ST_BUSY) && (cnt_q < n_q) && !rst;

    // Memory bus drive.
    always_comb begin
        mem_vis_addr   = '0;
        mem_vis_signal = SIG_IDLE;
        writen_data    = '0;
        if (bus_active) begin
            mem_vis_addr = base_q + ADDR_WIDTH'(cnt_q);
            if (we_q) begin
                mem_vis_signal = SIG_WRITE;
                writen_data    = wdata_q[wr_lane*BYTE_SIZE +: BYTE_SIZE];
            end else if (grant_q == PORT_INST) begin
                mem_vis_signal = SIG_READ_INST;
            end else begin
                mem_vis_signal = SIG_READ_DATA;
            end
        end
    end

    // Only the port that owns the burst sees done, and only in RESP.
    assign inst_done  = (state_q == ST_RESP) && (grant_q == PORT_INST) && !rst;
    assign data_done  = (state_q == ST_RESP) && (grant_q == PORT_DATA) && !rst;
    assign inst_data  = inst_data_q;
    assign data_rdata = data_rdata_q;

endmodule
